// File: rtl/vl_wb_b3_pattern_master.sv
// Wishbone B3 memory exerciser: writes a seeded pattern into a window with 4-beat
// incrementing bursts, reads it back with the same burst shape and scores the compare.
module vl_wb_b3_pattern_master #(
  parameter logic [31:0] base_adr    = 32'h0,
  parameter int          nr_of_words = 16,
  parameter logic [15:0] seed        = 16'hA5A5
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        done,
  output logic        ok,
  output logic [7:0]  err_cnt,
  output logic [31:0] fail_adr
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WGAP, S_RD, S_RGAP, S_DONE} state_t;

  localparam logic [31:0] words_total = 32'(nr_of_words);

  state_t      state_q, state_d;
  logic [31:0] idx, idx_nxt;
  logic        beat_ack, last_beat, words_left, mismatch;

  function automatic logic [31:0] pattern(input logic [15:0] n);
    return {n ^ seed, ~n};
  endfunction

  // Bursts always start on a multiple of 4 words, so the low index bits are the beat number.
  assign idx_nxt    = idx + 32'd1;
  assign beat_ack   = wbm_stb_o & wbm_ack_i;
  assign last_beat  = (idx[1:0] == 2'b11);
  assign words_left = (idx != words_total);
  assign wbm_bte_o  = 2'b00;

  always_comb begin
    state_d  = state_q;
    mismatch = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_WR;
      S_WR:   if (beat_ack && last_beat) state_d = S_WGAP;
      S_WGAP: state_d = words_left ? S_WR : S_RD;
      S_RD: begin
        mismatch = beat_ack && (wbm_dat_i != pattern(idx[15:0]));
        if (beat_ack && last_beat) state_d = S_RGAP;
      end
      S_RGAP: state_d = words_left ? S_RD : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      idx       <= 32'd0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      wbm_sel_o <= 4'hF;
      wbm_cti_o <= 3'b000;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      done      <= 1'b0;
      ok        <= 1'b0;
      err_cnt   <= 8'd0;
      fail_adr  <= 32'd0;
    end else begin
      wbm_sel_o <= 4'hF;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx       <= 32'd0;
            err_cnt   <= 8'd0;
            fail_adr  <= 32'd0;
            ok        <= 1'b0;
            done      <= 1'b0;
            wbm_adr_o <= base_adr;
            wbm_dat_o <= pattern(16'd0);
            wbm_cti_o <= 3'b010;
            wbm_we_o  <= 1'b1;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
          end
        end
        S_WR, S_RD: begin
          if (mismatch) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (err_cnt == 8'd0)  fail_adr <= wbm_adr_o;
          end
          // Next beat's address/data/cti land on the ack edge for zero-wait back-to-back beats.
          if (beat_ack) begin
            idx <= idx_nxt;
            if (last_beat) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_cti_o <= 3'b000;
            end else begin
              wbm_adr_o <= base_adr + {idx_nxt[29:0], 2'b00};
              if (state_q == S_WR) wbm_dat_o <= pattern(idx_nxt[15:0]);
              wbm_cti_o <= (idx_nxt[1:0] == 2'b11) ? 3'b111 : 3'b010;
            end
          end
        end
        S_WGAP: begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_cti_o <= 3'b010;
          if (words_left) begin
            wbm_adr_o <= base_adr + {idx[29:0], 2'b00};
            wbm_dat_o <= pattern(idx[15:0]);
            wbm_we_o  <= 1'b1;
          end else begin
            idx       <= 32'd0;
            wbm_adr_o <= base_adr;
            wbm_we_o  <= 1'b0;
          end
        end
        S_RGAP: begin
          if (words_left) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_cti_o <= 3'b010;
            wbm_adr_o <= base_adr + {idx[29:0], 2'b00};
          end else begin
            done <= 1'b1;
            ok   <= (err_cnt == 8'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vl_wb_b3_pattern_master.sv
// Self-checking bench: two exercisers (16-word and 512-word windows) against behavioural
// slaves with random wait states and read corruption, scored by a word-level model.
module tb_vl_wb_b3_pattern_master;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 wb_clk = ~wb_clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: default parameters, backed by a small RAM model
  logic        start_a = 1'b0;
  logic [31:0] adr_a, dat_a, dat_i_a, fail_a;
  logic [3:0]  sel_a;
  logic [2:0]  cti_a;
  logic [1:0]  bte_a;
  logic        we_a, cyc_a, stb_a, ack_a, done_a, ok_a;
  logic [7:0]  err_a;

  // Instance B: 512 words, slave always returns zero
  logic        start_b = 1'b0;
  logic [31:0] adr_b, dat_b, fail_b;
  logic [3:0]  sel_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;
  logic        we_b, cyc_b, stb_b, ack_b, done_b, ok_b;
  logic [7:0]  err_b;

  vl_wb_b3_pattern_master dut_a (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start_a),
    .wbm_adr_o(adr_a), .wbm_dat_o(dat_a), .wbm_sel_o(sel_a), .wbm_cti_o(cti_a),
    .wbm_bte_o(bte_a), .wbm_we_o(we_a), .wbm_cyc_o(cyc_a), .wbm_stb_o(stb_a),
    .wbm_dat_i(dat_i_a), .wbm_ack_i(ack_a),
    .done(done_a), .ok(ok_a), .err_cnt(err_a), .fail_adr(fail_a)
  );

  vl_wb_b3_pattern_master #(.nr_of_words(512)) dut_b (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start_b),
    .wbm_adr_o(adr_b), .wbm_dat_o(dat_b), .wbm_sel_o(sel_b), .wbm_cti_o(cti_b),
    .wbm_bte_o(bte_b), .wbm_we_o(we_b), .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b),
    .wbm_dat_i(32'h0), .wbm_ack_i(ack_b),
    .done(done_b), .ok(ok_b), .err_cnt(err_b), .fail_adr(fail_b)
  );

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_word(input int n);
    logic [15:0] nn;
    nn = n[15:0];
    return {nn ^ 16'hA5A5, ~nn};
  endfunction

  // Slave A: RAM with a random number of wait states per beat and optional read corruption
  logic [31:0] mem_a [0:15];
  int          wcnt_a = 0, need_a = 0, wait_lo = 0, wait_hi = 0;
  logic [15:0] corrupt_mask = 16'h0;
  logic [31:0] corrupt_xor = 32'h1;

  assign ack_a   = cyc_a & stb_a & (wcnt_a >= need_a);
  assign dat_i_a = mem_a[adr_a[5:2]] ^ ((!we_a && corrupt_mask[adr_a[5:2]]) ? corrupt_xor : 32'h0);
  assign ack_b   = cyc_b & stb_b;

  always @(posedge wb_clk) begin
    if (cyc_a && stb_a) begin
      if (ack_a) begin
        if (we_a) mem_a[adr_a[5:2]] <= dat_a;
        wcnt_a <= 0;
        need_a <= $urandom_range(wait_hi, wait_lo);
      end else begin
        wcnt_a <= wcnt_a + 1;
      end
    end else begin
      wcnt_a <= 0;
      need_a <= $urandom_range(wait_hi, wait_lo);
    end
  end

  // Protocol monitors, restarted whenever the stimulus bumps run_id
  int   run_id = 0, seen_a = -1, seen_b = -1;
  int   wbeat, rbeat, bursts, idle_run, bbeat;
  logic prev_cyc, prev_stall;
  logic [67:0] prev_bus;

  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      if (seen_a != run_id) begin
        seen_a = run_id; wbeat = 0; rbeat = 0; bursts = 0; idle_run = 0;
        prev_cyc = 1'b0; prev_stall = 1'b0;
      end
      if (cyc_a) begin
        if (!prev_cyc) begin
          if (bursts > 0) checkOutput("idle_gap", idle_run, 1);
          bursts++;
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
      if (cyc_a && stb_a) begin
        if (prev_stall) checkOutput("hold_during_wait", {adr_a, dat_a, cti_a, we_a}, prev_bus);
        if (ack_a) begin
          checkOutput("sel_bte", {sel_a, bte_a}, {4'hF, 2'b00});
          if (we_a) begin
            checkOutput("cti_wr", cti_a, (wbeat % 4 == 3) ? 3'b111 : 3'b010);
            checkOutput("adr_wr", adr_a, 4 * wbeat);
            checkOutput("dat_wr", dat_a, model_word(wbeat));
            wbeat++;
          end else begin
            checkOutput("cti_rd", cti_a, (rbeat % 4 == 3) ? 3'b111 : 3'b010);
            checkOutput("adr_rd", adr_a, 4 * rbeat);
            rbeat++;
          end
        end
        prev_stall = !ack_a;
        prev_bus   = {adr_a, dat_a, cti_a, we_a};
      end else begin
        prev_stall = 1'b0;
      end
      prev_cyc = cyc_a;
    end
  end

  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      if (seen_b != run_id) begin
        seen_b = run_id; bbeat = 0;
      end
      if (cyc_b && stb_b) begin
        checkOutput("b_cti", cti_b, (bbeat % 4 == 3) ? 3'b111 : 3'b010);
        checkOutput("b_sel_bte", {sel_b, bte_b}, {4'hF, 2'b00});
        if (we_b) checkOutput("b_dat_wr", dat_b, model_word(int'(adr_b >> 2)));
        bbeat++;
      end
    end
  end

  // One start pulse, then count edges until done; optionally re-pulse start while busy
  task automatic applyStimulus(input bit use_b, input bit extra_start, output int cycles);
    run_id++;
    @(posedge wb_clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    cycles = 0;
    forever begin
      @(posedge wb_clk); #1;
      cycles++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (extra_start && cycles == 3) start_a = 1'b1;
      if (use_b ? done_b : done_a) break;
      if (cycles > 5000) begin
        checkOutput("done_timeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  int          cyc_cnt, exp_err, exp_fail, lowest, wait_hi_pick;
  logic [31:0] mem_copy;

  initial begin
    repeat (3) @(posedge wb_clk);
    #1;
    checkOutput("rst_adr_dat", {adr_a, dat_a}, 64'h0);
    checkOutput("rst_ctl", {sel_a, cti_a, bte_a, we_a, cyc_a, stb_a, done_a, ok_a, err_a, fail_a},
                {4'hF, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0});
    wb_rst = 1'b0;

    // Zero-wait defaults, with a start pulse during the write phase that must be ignored
    applyStimulus(1'b0, 1'b1, cyc_cnt);
    checkOutput("cycles_zero_wait", cyc_cnt, 41);
    checkOutput("ok_clean", {ok_a, err_a, fail_a}, {1'b1, 8'h0, 32'h0});
    mem_copy = mem_a[5];
    checkOutput("word5", mem_copy, 32'hA5A0FFFA);
    for (int i = 0; i < 16; i++) begin
      mem_copy = mem_a[i];
      checkOutput("mem_word", mem_copy, model_word(i));
    end
    checkOutput("write_beats", wbeat, 16);
    checkOutput("read_beats", rbeat, 16);

    // Two wait states on every beat
    wait_lo = 2; wait_hi = 2;
    applyStimulus(1'b0, 1'b0, cyc_cnt);
    checkOutput("cycles_wait2", cyc_cnt, 2 * (16 * 3 + 4) + 1);
    checkOutput("ok_wait2", {done_a, ok_a, err_a}, {1'b1, 1'b1, 8'h0});

    // Single corrupted read of word 6
    wait_lo = 0; wait_hi = 0;
    corrupt_mask = 16'h0040; corrupt_xor = 32'h1;
    applyStimulus(1'b0, 1'b0, cyc_cnt);
    checkOutput("corrupt6", {ok_a, err_a, fail_a}, {1'b0, 8'h1, 32'h18});

    // Random wait states and random corruption sets
    for (int t = 0; t < 6; t++) begin
      wait_hi_pick = $urandom_range(3, 0);
      wait_lo = 0; wait_hi = wait_hi_pick;
      corrupt_mask = 16'($urandom);
      if ($urandom_range(3, 0) == 0) corrupt_mask = 16'h0;
      corrupt_xor = $urandom | 32'h1;
      exp_err = 0; lowest = -1;
      for (int i = 0; i < 16; i++) begin
        if (corrupt_mask[i]) begin
          exp_err++;
          if (lowest < 0) lowest = i;
        end
      end
      exp_fail = (lowest < 0) ? 0 : 4 * lowest;
      applyStimulus(1'b0, 1'b0, cyc_cnt);
      checkOutput("rand_result", {done_a, ok_a, err_a, fail_a},
                  {1'b1, (exp_err == 0), 8'(exp_err), 32'(exp_fail)});
      checkOutput("rand_read_beats", rbeat, 16);
    end
    corrupt_mask = 16'h0; wait_lo = 0; wait_hi = 0;

    // 512 words read back as zero: error count saturates
    applyStimulus(1'b1, 1'b0, cyc_cnt);
    checkOutput("cycles_512", cyc_cnt, 2 * (512 + 128) + 1);
    checkOutput("sat_result", {ok_b, err_b, fail_b}, {1'b0, 8'hFF, 32'h0});

    // Reset asserted in the middle of the first read burst
    run_id++;
    @(posedge wb_clk); #1;
    start_a = 1'b1;
    @(posedge wb_clk); #1;
    start_a = 1'b0;
    cyc_cnt = 0;
    while (!(cyc_a && !we_a) && cyc_cnt < 200) begin
      @(posedge wb_clk); #1;
      cyc_cnt++;
    end
    checkOutput("reached_read", {cyc_a, we_a}, {1'b1, 1'b0});
    repeat ($urandom_range(2, 0)) @(posedge wb_clk);
    #2 wb_rst = 1'b1;
    #1;
    checkOutput("mid_reset", {cyc_a, stb_a, done_a, we_a, cti_a, adr_a}, {1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0});
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, cyc_cnt);
    checkOutput("rerun_cycles", cyc_cnt, 41);
    checkOutput("rerun_ok", {ok_a, err_a, fail_a}, {1'b1, 8'h0, 32'h0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vl_wb_b3_pattern_master.md
# vl_wb_b3_pattern_master

Wishbone B3 master that sits directly upstream of the byte-enable Wishbone RAM slave and acts as a self-checking memory exerciser. On a start pulse it fills a window of the slave with a deterministic pattern using 4-beat incrementing bursts. It then reads the window back with the same burst shape and compares every word. It reports completion, pass/fail, an error count and the first failing address, and serves as both the bring-up stimulus and the traffic source for RAM regression benches.

## Interface
Parameters:
- `base_adr`, 32'h0 – byte address of first word; must be 16-byte aligned
- `nr_of_words`, 16 – words exercised; multiple of 4, ≥4
- `seed`, 16'hA5A5 – pattern seed

Ports:
- `wb_clk`  in  1  – clock; all logic rising-edge
- `wb_rst`  in  1  – asynchronous, active-high reset
- `start`  in  1  – one-cycle pulse; ignored unless in IDLE or DONE
- `wbm_adr_o`  out  32  – byte address
- `wbm_dat_o`  out  32  – write data
- `wbm_sel_o`  out  4  – byte selects; always 4'hF
- `wbm_cti_o`  out  3  – 3'b010 incrementing, 3'b111 end-of-burst
- `wbm_bte_o`  out  2  – always 2'b00 (linear)
- `wbm_we_o`  out  1  – write enable
- `wbm_cyc_o`  out  1  – cycle
- `wbm_stb_o`  out  1  – strobe
- `wbm_dat_i`  in  32  – read data
- `wbm_ack_i`  in  1  – acknowledge
- `done`  out  1  – high in DONE state
- `ok`  out  1  – valid when done; 1 = zero mismatches
- `err_cnt`  out  8  – mismatch count, saturates at 8'hFF
- `fail_adr`  out  32  – byte address of first mismatch; 0 if none

## Operation
- Pattern for word index n (0..nr_of_words-1): `{n[15:0] ^ seed, ~n[15:0]}`.
- Address of word n: `base_adr + 4*n`.
- States:
  - IDLE: bus idle. `start` → WR; clears `err_cnt`, `fail_adr`, `ok`, and word index.
  - WR: 4-beat write burst.
  - WGAP: one cycle with cyc/stb low. → WR if words remain, else → RD with index reset to 0.
  - RD: 4-beat read burst.
  - RGAP: one cycle idle. → RD if words remain, else → DONE.
  - DONE: `done`=1; `ok` = (`err_cnt`==0). `start` → WR with a fresh clear.
- Within a burst:
  - Beats 0–2 drive cti 010; beat 3 drives cti 111.
  - The beat advances only on a cycle with `wbm_ack_i`=1.
- Read compare happens on the ack cycle. On a mismatch:
  - `err_cnt` increments, saturating at 8'hFF.
  - `fail_adr` latches the current address only if `err_cnt` was 0.
- `wbm_ack_i` outside an active stb is ignored; it does not advance state.
- `err`/`rty` are not supported. A slave that never acks stalls the block indefinitely; this is by design.

## Timing
- All outputs are registered.
- Reset values: adr 0, dat 0, sel 4'hF, cti 000, bte 00, we 0, cyc 0, stb 0, done 0, ok 0, err_cnt 0, fail_adr 0.
- Startup: `start` sampled at edge k → cyc=stb=1, we=1, adr=base_adr, cti=010 from edge k+1.
- Handshake:
  - Master holds adr, dat, cti and we stable while stb=1 and ack=0.
  - On the edge that samples ack=1, the next beat's adr/dat/cti take effect, so zero-wait-state back-to-back acks are supported.
- Burst end: after the ack on beat 3, cyc and stb deassert at that same edge (WGAP/RGAP), so there is exactly 1 idle cycle between bursts.
- Total cycles, for a zero-wait slave, from `start` to `done`:
  - Write phase: `nr_of_words` + `nr_of_words`/4.
  - Read phase: `nr_of_words` + `nr_of_words`/4.
  - Plus 1 cycle for the transition to DONE.
- The DONE register asserts at the edge that follows the final RGAP.
- Reset mid-operation: all outputs return to reset values asynchronously. No burst completion is attempted.
- `start` while busy has no effect.

## Test plan
- **Zero-wait RAM, defaults:** pulse start → 4 write bursts at 0x0/0x10/0x20/0x30; word 5 is 0xA5A0FFFA; done after 41 cycles; ok=1, err_cnt=0, fail_adr=0.
- **Slave inserting 2 wait states per beat:** all master outputs stay stable during waits; done is reached; ok=1.
- **Corruption of the read of word 6 (dat_i xor 1):** done with ok=0, err_cnt=1, fail_adr=0x18.
- **All reads forced to 0, nr_of_words=512:** err_cnt saturates at 0xFF; fail_adr=0x0.
- **wb_rst asserted mid-read-burst:** cyc/stb/done drop immediately. A subsequent start re-runs cleanly with ok=1.
- **Protocol checks:**
  - cti=111 exactly on every 4th beat.
  - cyc low for exactly 1 cycle between bursts.
  - start pulsed during WR is ignored; the total cycle count is unchanged.
